execute_mc: RTL
===============

EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (>=8, power of two).
REQ-002 Parameter NFWD, default 4, number of forwarding sources beyond register-file operands.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operation presented this cycle.
REQ-006 op  in  4  ALU operation code.
REQ-007 branch, jump, branch_op  in  1/1/2  control-flow request; branch condition: 0 EQZ, 1 NEZ, 2 LTZ, 3 GEZ.
REQ-008 rd1, rd2, imm, pc  in  WIDTH each  register-file operands, immediate, current PC.
REQ-009 alu_src  in  1  selects imm instead of forwarded B as second ALU operand.
REQ-010 fwd_sel_a, fwd_sel_b  in  $clog2(NFWD+1) each  0 selects register file; k selects forwarding source k-1.
REQ-011 fwd_data  in  NFWD*WIDTH  packed forwarding sources, source 0 in LSBs.
REQ-012 stall  out  1  unit busy; upstream holds its operation.
REQ-013 out_valid, result, next_pc, rt  out  1/WIDTH/WIDTH/WIDTH  registered result, resolved PC, forwarded B.
REQ-014 taken, err  out  1/1  registered control-flow outcome and error.

Function
REQ-015 Operation accepted on a rising edge where in_valid=1 and stall=0; otherwise inputs ignored.
REQ-016 Forwarded A/B resolved combinationally at acceptance; fwd_sel values above NFWD select the register-file operand.
REQ-017 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 PASSB, 10 MUL; shift amount = low $clog2(WIDTH) bits of B.
REQ-018 Ops 11-15 reserved: result 0, err=1, out_valid=1.
REQ-019 Non-MUL ops: out_valid, result, next_pc, taken, err registered one cycle after acceptance; out_valid otherwise 0 (single-cycle pulse).
REQ-020 ADD/SUB wrap modulo 2^WIDTH; arithmetic overflow does not set err.
REQ-021 Branch condition evaluated on forwarded A: EQZ A==0, NEZ A!=0, LTZ A[WIDTH-1], GEZ !A[WIDTH-1].
REQ-022 taken = jump | (branch & condition); next_pc = taken ? pc+imm : pc+2.
REQ-023 err = taken & signed overflow of pc+imm.
REQ-024 FSM states IDLE, MUL: IDLE->MUL on accepted MUL; MUL->IDLE after WIDTH iterations; stall = (state==MUL).
REQ-025 MUL latches A and B at acceptance; iterative shift-add, one bit per cycle; result = low WIDTH bits of product.
REQ-026 MUL accepted at edge k: out_valid and result at edge k+WIDTH; next accept no earlier than edge k+WIDTH+1.
REQ-027 MUL with branch or jump asserted: control flow resolved with the MUL result at edge k+WIDTH.
REQ-028 Changes on forwarding inputs during MUL do not affect the product.

Reset
REQ-029 On rst: state IDLE, iteration counter 0, stall 0, out_valid 0, taken 0, err 0, result 0, next_pc 0.
REQ-030 rst mid-MUL aborts the operation; no out_valid produced for it.

Configuration
REQ-031 Macro EXECUTE_MC_MUL_EN: defined, MUL per REQ-024..028; undefined, no FSM or multiplier, stall tied 0, op 10 treated as reserved per REQ-018.

Structure
REQ-032 Package exec_pkg holds op codes, branch_op codes, FSM state typedef, and the fwd_sel register-file constant.
REQ-033 The iterative multiplier is sub-module exec_mul (start, done, operands, product); instantiated only under EXECUTE_MC_MUL_EN.

Verification (WIDTH=16, NFWD=4)
REQ-034 ADD rd1=0x7FFF, rd2=0x0001 -> next cycle out_valid=1, result=0x8000, err=0.
REQ-035 AND fwd_sel_a=3, source 2=0x1234, rd2=0x00FF -> result=0x0034.
REQ-036 MUL A=300, B=250 -> stall=1 for 16 cycles, out_valid at edge 16, result=0x24F8; in_valid during stall ignored.
REQ-037 branch LTZ, A=0x8000, pc=0x0010, imm=0x0020 -> taken=1, next_pc=0x0030; NEZ with A=0 -> taken=0, next_pc=0x0012.
REQ-038 jump pc=0x7FF0, imm=0x0020 -> taken=1, err=1.
REQ-039 rst at MUL cycle 5 -> next cycle stall=0, out_valid=0; ADD accepted the following cycle completes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch conditions,
// multiplier FSM states and the forwarding-select value that picks the register file.
package exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  localparam logic [1:0] BR_EQZ = 2'd0;
  localparam logic [1:0] BR_NEZ = 2'd1;
  localparam logic [1:0] BR_LTZ = 2'd2;
  localparam logic [1:0] BR_GEZ = 2'd3;

  localparam int unsigned FWD_SEL_RF = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic branch_cond(input logic [1:0] bop,
                                       input logic       a_zero,
                                       input logic       a_neg);
    logic c;
    case (bop)
      BR_EQZ:  c = a_zero;
      BR_NEZ:  c = ~a_zero;
      BR_LTZ:  c = a_neg;
      BR_GEZ:  c = ~a_neg;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; done is raised
// during the final iteration so the caller can register product on that edge.
module exec_mul
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] addend_s;

  // Next-state for the operand shifters, accumulator and iteration counter.
  always_comb begin
    addend_s = b_q[0] ? a_q : {WIDTH{1'b0}};
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = {CW{1'b0}};
      a_d    = a;
      b_d    = b;
      acc_d  = {WIDTH{1'b0}};
    end else if (busy_q) begin
      acc_d  = acc_q + addend_s;
      a_d    = a_q << 1;
      b_d    = b_q >> 1;
      cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      busy_d = (cnt_q != CW'(WIDTH - 1));
    end else begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      a_q    <= {WIDTH{1'b0}};
      b_q    <= {WIDTH{1'b0}};
      acc_q  <= {WIDTH{1'b0}};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

  // Product includes the last partial sum so it is valid on the done edge.
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_q + addend_s;

endmodule

// File: rtl/execute_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution and,
// when EXECUTE_MC_MUL_EN is defined, a multi-cycle MUL that stalls the upstream stage.
module execute_mc
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NFWD  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [3:0]                    op,
  input  logic                          branch,
  input  logic                          jump,
  input  logic [1:0]                    branch_op,
  input  logic [WIDTH-1:0]              rd1,
  input  logic [WIDTH-1:0]              rd2,
  input  logic [WIDTH-1:0]              imm,
  input  logic [WIDTH-1:0]              pc,
  input  logic                          alu_src,
  input  logic [$clog2(NFWD+1)-1:0]     fwd_sel_a,
  input  logic [$clog2(NFWD+1)-1:0]     fwd_sel_b,
  input  logic [NFWD*WIDTH-1:0]         fwd_data,
  output logic                          stall,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              result,
  output logic [WIDTH-1:0]              next_pc,
  output logic [WIDTH-1:0]              rt,
  output logic                          taken,
  output logic                          err
);

  localparam int SELW = $clog2(NFWD + 1);
  localparam int SHW  = $clog2(WIDTH);

  logic [WIDTH-1:0] fwd_a_s, fwd_b_s, op_b_s, alu_s, target_s, next_pc_s;
  logic [SHW-1:0]   shamt_s;
  logic             err_op_s, cond_s, taken_s, ovf_s, err_s;
  logic             accept_s, is_mul_s, mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0] mul_next_pc_s, mul_rt_s;
  logic             mul_taken_s, mul_err_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic             taken_q, taken_d;
  logic             err_q, err_d;

  // Forwarding muxes; any select outside 1..NFWD falls back to the register file.
  always_comb begin
    fwd_a_s = rd1;
    fwd_b_s = rd2;
    for (int k = 0; k < NFWD; k++) begin
      if (fwd_sel_a == SELW'(k + 1)) fwd_a_s = fwd_data[k*WIDTH +: WIDTH];
      else                           fwd_a_s = fwd_a_s;
      if (fwd_sel_b == SELW'(k + 1)) fwd_b_s = fwd_data[k*WIDTH +: WIDTH];
      else                           fwd_b_s = fwd_b_s;
    end
  end

  assign op_b_s  = alu_src ? imm : fwd_b_s;
  assign shamt_s = op_b_s[SHW-1:0];

  // Single-cycle ALU; unassigned op codes produce zero and flag an error.
  always_comb begin
    alu_s    = {WIDTH{1'b0}};
    err_op_s = 1'b0;
    case (op)
      OP_ADD:   alu_s = fwd_a_s + op_b_s;
      OP_SUB:   alu_s = fwd_a_s - op_b_s;
      OP_AND:   alu_s = fwd_a_s & op_b_s;
      OP_OR:    alu_s = fwd_a_s | op_b_s;
      OP_XOR:   alu_s = fwd_a_s ^ op_b_s;
      OP_SLL:   alu_s = fwd_a_s << shamt_s;
      OP_SRL:   alu_s = fwd_a_s >> shamt_s;
      OP_SRA:   alu_s = $unsigned($signed(fwd_a_s) >>> shamt_s);
      OP_SLT:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
      OP_PASSB: alu_s = op_b_s;
`ifdef EXECUTE_MC_MUL_EN
      OP_MUL:   alu_s = {WIDTH{1'b0}};
`endif
      default: begin
        alu_s    = {WIDTH{1'b0}};
        err_op_s = 1'b1;
      end
    endcase
  end

  assign cond_s    = branch_cond(branch_op, (fwd_a_s == {WIDTH{1'b0}}), fwd_a_s[WIDTH-1]);
  assign taken_s   = jump | (branch & cond_s);
  assign target_s  = pc + imm;
  assign ovf_s     = (pc[WIDTH-1] == imm[WIDTH-1]) && (target_s[WIDTH-1] != pc[WIDTH-1]);
  assign next_pc_s = taken_s ? target_s : (pc + WIDTH'(2));
  assign err_s     = err_op_s | (taken_s & ovf_s);
  assign accept_s  = in_valid & ~stall;

`ifdef EXECUTE_MC_MUL_EN
  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_next_pc_q, hold_next_pc_d;
  logic [WIDTH-1:0] hold_rt_q, hold_rt_d;
  logic             hold_taken_q, hold_taken_d;
  logic             hold_err_q, hold_err_d;
  logic             mul_start_s;

  assign is_mul_s    = (op == OP_MUL);
  assign mul_start_s = accept_s & is_mul_s;

  exec_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .a       (fwd_a_s),
    .b       (op_b_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // FSM next state plus control-flow outcome captured at MUL acceptance.
  always_comb begin
    state_d        = state_q;
    hold_next_pc_d = hold_next_pc_q;
    hold_rt_d      = hold_rt_q;
    hold_taken_d   = hold_taken_q;
    hold_err_d     = hold_err_q;
    case (state_q)
      ST_IDLE: state_d = mul_start_s ? ST_MUL : ST_IDLE;
      ST_MUL:  state_d = mul_done_s ? ST_IDLE : ST_MUL;
      default: state_d = ST_IDLE;
    endcase
    if (mul_start_s) begin
      hold_next_pc_d = next_pc_s;
      hold_rt_d      = fwd_b_s;
      hold_taken_d   = taken_s;
      hold_err_d     = err_s;
    end else begin
      hold_taken_d   = hold_taken_q;
    end
  end

  // Multiplier FSM state and held control-flow results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hold_next_pc_q <= {WIDTH{1'b0}};
      hold_rt_q      <= {WIDTH{1'b0}};
      hold_taken_q   <= 1'b0;
      hold_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_next_pc_q <= hold_next_pc_d;
      hold_rt_q      <= hold_rt_d;
      hold_taken_q   <= hold_taken_d;
      hold_err_q     <= hold_err_d;
    end
  end

  assign stall         = (state_q == ST_MUL);
  assign mul_next_pc_s = hold_next_pc_q;
  assign mul_rt_s      = hold_rt_q;
  assign mul_taken_s   = hold_taken_q;
  assign mul_err_s     = hold_err_q;
`else
  assign stall         = 1'b0;
  assign is_mul_s      = 1'b0;
  assign mul_done_s    = 1'b0;
  assign mul_prod_s    = {WIDTH{1'b0}};
  assign mul_next_pc_s = {WIDTH{1'b0}};
  assign mul_rt_s      = {WIDTH{1'b0}};
  assign mul_taken_s   = 1'b0;
  assign mul_err_s     = 1'b0;
`endif

  // Output register loading: single-cycle ops on accept, MUL on its done edge.
  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    next_pc_d   = next_pc_q;
    rt_d        = rt_q;
    taken_d     = taken_q;
    err_d       = err_q;
    if (accept_s && !is_mul_s) begin
      out_valid_d = 1'b1;
      result_d    = alu_s;
      next_pc_d   = next_pc_s;
      rt_d        = fwd_b_s;
      taken_d     = taken_s;
      err_d       = err_s;
    end else if (mul_done_s) begin
      out_valid_d = 1'b1;
      result_d    = mul_prod_s;
      next_pc_d   = mul_next_pc_s;
      rt_d        = mul_rt_s;
      taken_d     = mul_taken_s;
      err_d       = mul_err_s;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      next_pc_q   <= {WIDTH{1'b0}};
      rt_q        <= {WIDTH{1'b0}};
      taken_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      next_pc_q   <= next_pc_d;
      rt_q        <= rt_d;
      taken_q     <= taken_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign next_pc   = next_pc_q;
  assign rt        = rt_q;
  assign taken     = taken_q;
  assign err       = err_q;

endmodule
